// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai_gm_pipe.sv
// Pipelined OR-AND-INVERT: ZN = ~&(|group_g) over GROUPS groups of WIDTH bits, 2-stage valid/ready.
// Optional mux-scan chain SI -> s1 -> v1 -> v2 -> ZN -> SO when OAI_GM_SCAN_EN is defined.
module gf180mcu_fd_sc_mcu7t5v0__oai_gm_pipe #(
  parameter int unsigned GROUPS = 2,
  parameter int unsigned WIDTH  = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [GROUPS*WIDTH-1:0]   A,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic                      ZN,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY
`ifdef OAI_GM_SCAN_EN
  ,
  input  logic                      SE,
  input  logic                      SI,
  output logic                      SO
`endif
);

  logic [GROUPS-1:0] s1;
  logic [GROUPS-1:0] grp_or;
  logic              v1;
  logic              v2;
  logic              zn_q;
  logic              adv2;
  logic              scan_en;

`ifdef OAI_GM_SCAN_EN
  logic [GROUPS:0]   scan_shift;
  assign scan_en    = SE;
  assign scan_shift = {s1, SI};
  assign SO         = zn_q;
`else
  assign scan_en    = 1'b0;
`endif

  // Per-group OR reduction of the incoming operand.
  always_comb begin
    grp_or = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      grp_or[g] = |A[g*WIDTH +: WIDTH];
    end
  end

  assign adv2      = ~v2 | OUT_READY;
  assign IN_READY  = ~scan_en & (~v1 | adv2);
  assign OUT_VALID = v2 & ~scan_en;
  assign ZN        = zn_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1   <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      zn_q <= 1'b1;
    end
`ifdef OAI_GM_SCAN_EN
    else if (scan_en) begin
      s1   <= scan_shift[GROUPS-1:0];
      v1   <= s1[GROUPS-1];
      v2   <= v1;
      zn_q <= v2;
    end
`endif
    else begin
      // Stage 1: a new accept replaces data being drained to stage 2 in the same cycle.
      if (IN_VALID && IN_READY) begin
        s1 <= grp_or;
        v1 <= 1'b1;
      end else if (v1 && adv2) begin
        v1 <= 1'b0;
      end

      // Stage 2: output register holds while the consumer stalls.
      if (v1 && adv2) begin
        zn_q <= ~&s1;
        v2   <= 1'b1;
      end else if (OUT_READY) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai_gm_pipe.sv
// Directed self-checking bench for the pipelined OAI block (default GROUPS=2, WIDTH=3).
module tb_gf180mcu_fd_sc_mcu7t5v0__oai_gm_pipe;

  localparam int unsigned GROUPS = 2;
  localparam int unsigned WIDTH  = 3;
  localparam int unsigned AW     = GROUPS * WIDTH;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] A;
  logic          IN_VALID;
  logic          IN_READY;
  logic          ZN;
  logic          OUT_VALID;
  logic          OUT_READY;
`ifdef OAI_GM_SCAN_EN
  logic          SE;
  logic          SI;
  logic          SO;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gf180mcu_fd_sc_mcu7t5v0__oai_gm_pipe #(.GROUPS(GROUPS), .WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ZN        (ZN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
`ifdef OAI_GM_SCAN_EN
    ,
    .SE        (SE),
    .SI        (SI),
    .SO        (SO)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [AW-1:0] svec [4];
  logic          sexp [4];

  initial begin
    RST       = 1'b1;
    A         = '1;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
`ifdef OAI_GM_SCAN_EN
    SE = 1'b0;
    SI = 1'b0;
`endif

    // Reset with valid all-ones input present.
    tick();
    tick();
    check_eq("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check_eq("rst_zn", 32'(ZN), 32'd1);
    RST      = 1'b0;
    IN_VALID = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(IN_READY), 32'd1);

    // Single transaction: 000_001 -> groups (1,0) -> ZN=1.
    A        = 6'b000_001;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check_eq("f1_not_yet", 32'(OUT_VALID), 32'd0);
    tick();
    check_eq("f1_valid", 32'(OUT_VALID), 32'd1);
    check_eq("f1_zn", 32'(ZN), 32'd1);
    tick();
    check_eq("f1_drain", 32'(OUT_VALID), 32'd0);

    // 010_100 -> groups (1,1) -> ZN=0.
    A        = 6'b010_100;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check_eq("f2_not_yet", 32'(OUT_VALID), 32'd0);
    tick();
    check_eq("f2_valid", 32'(OUT_VALID), 32'd1);
    check_eq("f2_zn", 32'(ZN), 32'd0);
    tick();
    tick();

    // Streaming: four back-to-back vectors.
    svec[0] = 6'b111_000; sexp[0] = 1'b1;
    svec[1] = 6'b001_001; sexp[1] = 1'b0;
    svec[2] = 6'b000_000; sexp[2] = 1'b1;
    svec[3] = 6'b100_010; sexp[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      IN_VALID = (i < 4);
      A        = (i < 4) ? svec[i] : '0;
      tick();
      if (i == 0) begin
        check_eq("st_first_empty", 32'(OUT_VALID), 32'd0);
      end else if (i <= 4) begin
        check_eq($sformatf("st_valid%0d", i - 1), 32'(OUT_VALID), 32'd1);
        check_eq($sformatf("st_zn%0d", i - 1), 32'(ZN), 32'(sexp[i-1]));
      end else begin
        check_eq("st_end", 32'(OUT_VALID), 32'd0);
      end
    end
    IN_VALID = 1'b0;
    tick();

    // Backpressure: fill both stages with X(ZN=1) and Y(ZN=0), offer Z(ZN=1) while stalled.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    A         = 6'b000_001;
    tick();
    A = 6'b011_110;
    tick();
    A = 6'b000_000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp_in_ready%0d", i), 32'(IN_READY), 32'd0);
      check_eq($sformatf("bp_valid%0d", i), 32'(OUT_VALID), 32'd1);
      check_eq($sformatf("bp_zn%0d", i), 32'(ZN), 32'd1);
      tick();
    end
    OUT_READY = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    check_eq("bp_y_valid", 32'(OUT_VALID), 32'd1);
    check_eq("bp_y_zn", 32'(ZN), 32'd0);
    tick();
    check_eq("bp_z_valid", 32'(OUT_VALID), 32'd1);
    check_eq("bp_z_zn", 32'(ZN), 32'd1);
    tick();
    check_eq("bp_empty", 32'(OUT_VALID), 32'd0);

    // Reset mid-flight with both stages holding ZN=0 results.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    A         = 6'b010_100;
    tick();
    A = 6'b111_111;
    tick();
    IN_VALID = 1'b0;
    check_eq("mr_full_zn", 32'(ZN), 32'd0);
    RST = 1'b1;
    tick();
    RST       = 1'b0;
    OUT_READY = 1'b1;
    check_eq("mr_valid", 32'(OUT_VALID), 32'd0);
    check_eq("mr_zn", 32'(ZN), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("mr_quiet%0d", i), 32'(OUT_VALID), 32'd0);
    end

`ifdef OAI_GM_SCAN_EN
    // Scan shift: pattern appears on SO after chain-length edges.
    begin
      localparam int unsigned LEN = GROUPS + 3;
      logic [31:0] pat;
      logic        bits [64];
      pat = 32'h59;
      for (int i = 0; i < 2 * int'(LEN); i++) begin
        bits[i] = (i < int'(LEN)) ? pat[int'(LEN) - 1 - i] : 1'b0;
      end
      SE = 1'b1;
      for (int j = 1; j <= 2 * int'(LEN); j++) begin
        SI = bits[j-1];
        tick();
        check_eq($sformatf("scan_ov%0d", j), 32'(OUT_VALID), 32'd0);
        if (j >= int'(LEN)) begin
          check_eq($sformatf("scan_so%0d", j), 32'(SO), 32'(bits[j - int'(LEN)]));
        end
      end
      #1;
      check_eq("scan_in_ready", 32'(IN_READY), 32'd0);
      SE  = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
